conv3x3_window_gen: RTL and testbench
=====================================

CONV3X3_WINDOW_GEN -- requirements
Module: conv3x3_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning pixel bit width per channel.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, meaning channels per pixel.
REQ-003 SHALL have parameter IMG_WIDTH, default 32, meaning pixels per row (>=3).
REQ-004 SHALL have parameter IMG_HEIGHT, default 32, meaning rows per frame (>=3).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port in_valid  input  1  the input pixel is valid.
REQ-008 SHALL have port in_ready  output  1  the block accepts a pixel this cycle.
REQ-009 SHALL have port pix_in  input  signed DATA_WIDTH x [NUM_CHANNELS]  one pixel, all channels, in raster order.
REQ-010 SHALL have port win_valid  output  1  win_out holds a valid 3x3 window.
REQ-011 SHALL have port win_ready  input  1  the downstream consumes the window this cycle.
REQ-012 SHALL have port win_out  output  signed DATA_WIDTH x [NUM_CHANNELS][0:2][0:2]  window, shaped exactly as the conv core's data_in.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last window of a frame is consumed.

Function
REQ-014 A pixel SHALL be accepted when in_valid && in_ready.
REQ-015 A window SHALL transfer when win_valid && win_ready.
REQ-016 in_ready SHALL equal (!win_valid || win_ready) && state != FRAME_END.
REQ-017 Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on accepted pixels: col wraps to 0 and increments row; row wraps to 0 after the last pixel.
REQ-018 Two line buffers of IMG_WIDTH x NUM_CHANNELS SHALL hold rows row-1 and row-2; per-channel 3-deep column shift registers SHALL hold the last three columns of each of the three rows.
REQ-019 win_out[c][i][j] SHALL be channel c, row row-2+i, column col-2+j of the accepting pixel: [0][0] is oldest/top-left, [2][2] is the accepted pixel.
REQ-020 A window SHALL be produced only for accepted pixels with row>=2 and col>=2 (valid convolution, no padding): (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-021 win_valid and win_out SHALL register one cycle after the producing pixel is accepted (latency 1); win_out SHALL stay stable while win_valid && !win_ready.
REQ-022 If a window transfers in the same cycle that a new producing pixel is accepted, win_valid SHALL stay 1 with the new window loaded (no bubble).
REQ-023 FSM states: FILL (row<2), ACTIVE (row>=2), FRAME_END.
REQ-024 FILL->ACTIVE SHALL occur on acceptance of the last pixel of row 1.
REQ-025 ACTIVE->FRAME_END SHALL occur on acceptance of the last pixel of the frame.
REQ-026 FRAME_END->FILL SHALL occur when the final window transfers; frame_done SHALL pulse high for exactly that cycle.
REQ-027 Windows SHALL NOT straddle row boundaries: column shift registers restart at col 0 of every row.
REQ-028 Data SHALL pass through unmodified: no arithmetic and no width change.

Reset
REQ-029 On rst: state=FILL, row=0, col=0, win_valid=0, frame_done=0, win_out=0; in_ready=1 in the first cycle after reset.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is treated as (0,0); line buffer contents need not be cleared.

Structure
REQ-031 Package conv_pkg SHALL hold the DATA_WIDTH and NUM_CHANNELS defaults, a pixel typedef (signed DATA_WIDTH array of NUM_CHANNELS), a 3x3 window typedef, and the FSM state enum.
REQ-032 One sub-module SHALL exist: conv_line_buffer (IMG_WIDTH-deep single-port-per-cycle delay line for one pixel), instantiated twice.

Verification
REQ-033 Directed test, 4x4 frame, 1 channel, pixels 0..15, win_ready=1 -> 4 windows: {0,1,2;4,5,6;8,9,10}, {1,2,3;5,6,7;9,10,11}, {4,5,6;8,9,10;12,13,14}, {5,6,7;9,10,11;13,14,15}, each 1 cycle after pixels 10, 11, 14 and 15 are accepted.
REQ-034 Directed test, backpressure: same frame with win_ready=0 for 3 cycles after the first window -> win_out holds {0,1,2;4,5,6;8,9,10}, in_ready=0, and no pixel is lost.
REQ-035 Directed test, 3 channels with channel c pixel = 16*c+idx -> first window channel 2 = {32,33,34;36,37,38;40,41,42}.
REQ-036 Directed test, two back-to-back 4x4 frames -> frame_done pulses once per frame, in_ready=0 during FRAME_END, and the second frame's first window is correct.
REQ-037 Directed test, rst asserted after pixel 9 then a full frame -> no window is emitted from the partial frame and the new frame's output equals REQ-033.
REQ-038 Directed test, in_valid toggling 1/0 every cycle -> window values and order equal REQ-033.

Source files
------------

// File: rtl/conv3x3_window_gen_pkg.sv
// conv_pkg: shared defaults, pixel/window types and FSM state for the
// 3x3 window generator. No ports.
package conv_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_NUM_CHANNELS = 3;

  typedef logic signed [DEF_DATA_WIDTH-1:0]
    pixel_t [DEF_NUM_CHANNELS];

  typedef logic signed [DEF_DATA_WIDTH-1:0]
    window_t [DEF_NUM_CHANNELS][0:2][0:2];

  typedef enum logic [1:0] {
    FILL,
    ACTIVE,
    FRAME_END
  } state_e;

endpackage

// File: rtl/conv3x3_window_gen_if.sv
// Pixel-in / window-out handshake bundle.
// slave: block side (accepts pixels, emits windows); master: source/sink side.
interface conv3x3_window_gen_if #(
  parameter int DATA_WIDTH   = conv_pkg::DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = conv_pkg::DEF_NUM_CHANNELS
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] pix_in [NUM_CHANNELS];
  logic                         win_valid;
  logic                         win_ready;
  logic signed [DATA_WIDTH-1:0] win_out [NUM_CHANNELS][0:2][0:2];
  logic                         frame_done;

  modport slave (
    input  in_valid, pix_in, win_ready,
    output in_ready, win_valid, win_out, frame_done
  );

  modport master (
    output in_valid, pix_in, win_ready,
    input  in_ready, win_valid, win_out, frame_done
  );

endinterface

// File: rtl/conv3x3_window_gen_line_buffer.sv
// conv_line_buffer: one-row delay line, addressed by column.
// Ports: clk, en (write), addr (column), din (pixel in), dout (pixel one row ago).
module conv_line_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int DEPTH        = 32,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [AW-1:0]                addr,
  input  logic signed [DATA_WIDTH-1:0] din  [NUM_CHANNELS],
  output logic signed [DATA_WIDTH-1:0] dout [NUM_CHANNELS]
);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH][NUM_CHANNELS];

  // Read-before-write: dout is the value stored one row earlier.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      dout[c] = mem_q[addr][c];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        mem_q[addr][c] <= din[c];
      end
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream (valid conv, no pad).
// Ports: clk, rst (sync, high), io (slave: pixel in, window out, frame_done).
module conv3x3_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32
) (
  input logic                    clk,
  input logic                    rst,
  conv3x3_window_gen_if.slave    io
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef logic signed [DATA_WIDTH-1:0] px_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            win_valid_q, win_valid_d;
  px_t             win_q [NUM_CHANNELS][0:2][0:2];
  px_t             win_d [NUM_CHANNELS][0:2][0:2];
  px_t             sr_q  [NUM_CHANNELS][0:2][0:1];
  px_t             sr_d  [NUM_CHANNELS][0:2][0:1];
  px_t             up1   [NUM_CHANNELS];
  px_t             up2   [NUM_CHANNELS];
  px_t             colv  [NUM_CHANNELS][0:2];
  logic            in_ready;
  logic            accept;
  logic            xfer;
  logic            produce;
  logic            col_last;
  logic            row_last;

  conv_line_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS),
    .DEPTH       (IMG_WIDTH),
    .AW          (CW)
  ) u_lb1 (
    .clk (clk),
    .en  (accept),
    .addr(col_q),
    .din (io.pix_in),
    .dout(up1)
  );

  conv_line_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS),
    .DEPTH       (IMG_WIDTH),
    .AW          (CW)
  ) u_lb2 (
    .clk (clk),
    .en  (accept),
    .addr(col_q),
    .din (up1),
    .dout(up2)
  );

  always_comb begin
    in_ready = (!win_valid_q || io.win_ready)
             && (state_q != FRAME_END);
    accept   = io.in_valid && in_ready;
    xfer     = win_valid_q && io.win_ready;
    col_last = (col_q == CW'(IMG_WIDTH - 1));
    row_last = (row_q == RW'(IMG_HEIGHT - 1));
    produce  = accept && (row_q >= RW'(2))
             && (col_q >= CW'(2));

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
      end
    end

    // New column: row-2 (top), row-1, current pixel (bottom).
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      colv[c][0] = up2[c];
      colv[c][1] = up1[c];
      colv[c][2] = io.pix_in[c];
    end

    sr_d  = sr_q;
    win_d = win_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (produce) begin
          win_d[c][i][0] = sr_q[c][i][0];
          win_d[c][i][1] = sr_q[c][i][1];
          win_d[c][i][2] = colv[c][i];
        end
        if (accept) begin
          sr_d[c][i][0] = sr_q[c][i][1];
          sr_d[c][i][1] = colv[c][i];
        end
      end
    end

    // A new window replaces a departing one with no bubble.
    win_valid_d = produce ? 1'b1
                : (xfer ? 1'b0 : win_valid_q);

    state_d = state_q;
    unique case (state_q)
      FILL: if (accept && col_last && row_q == RW'(1))
        state_d = ACTIVE;
      ACTIVE: if (accept && col_last && row_last)
        state_d = FRAME_END;
      FRAME_END: if (xfer)
        state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
    if (rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            win_q[c][i][j] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  assign io.in_ready   = in_ready;
  assign io.win_valid  = win_valid_q;
  assign io.win_out    = win_q;
  assign io.frame_done = (state_q == FRAME_END) && xfer;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen: 4x4 frames, 3 channels,
// channel c of pixel k = 16*c + k.
module tb_conv3x3_window_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv3x3_window_gen_if #(
    .DATA_WIDTH  (8),
    .NUM_CHANNELS(3)
  ) dut_if ();

  conv3x3_window_gen #(
    .DATA_WIDTH  (8),
    .NUM_CHANNELS(3),
    .IMG_WIDTH   (4),
    .IMG_HEIGHT  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (dut_if.slave)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    for (int c = 0; c < 3; c++)
      dut_if.pix_in[c] = 8'(16 * c + k);
  endtask

  task automatic send(input int k);
    drive(k);
    dut_if.in_valid = 1'b1;
    #1;
    chk($sformatf("in_ready_px%0d", k), dut_if.in_ready, 1);
    @(posedge clk);
    #1;
    dut_if.in_valid = 1'b0;
  endtask

  // Window for bottom-right pixel p in a 4x4 frame: top-left is p-10.
  task automatic chk_win(input string tag, input int p);
    chk({tag, "_valid"}, dut_if.win_valid, 1);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("%s_p%0d_c%0d_%0d%0d", tag, p, c, i, j),
              dut_if.win_out[c][i][j],
              16 * c + p - 10 + 4 * i + j);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_win_valid"}, dut_if.win_valid, 0);
    chk({tag, "_frame_done"}, dut_if.frame_done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dut_if.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_win_valid", dut_if.win_valid, 0);
    chk("rst_frame_done", dut_if.frame_done, 0);
    chk("rst_in_ready", dut_if.in_ready, 1);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("rst_win_%0d%0d%0d", c, i, j),
              dut_if.win_out[c][i][j], 0);
  endtask

  task automatic run_frame(input bit bp, input bit tog);
    for (int k = 0; k < 16; k++) begin
      if (bp && k == 11) begin
        dut_if.win_ready = 1'b0;
        drive(11);
        dut_if.in_valid = 1'b1;
        repeat (3) begin
          #1;
          chk("bp_in_ready", dut_if.in_ready, 0);
          @(posedge clk);
          #1;
          chk_win("bp_hold", 10);
        end
        dut_if.win_ready = 1'b1;
      end
      send(k);
      if (k == 10 || k == 11 || k == 14 || k == 15)
        chk_win("win", k);
      else
        chk_idle($sformatf("idle_px%0d", k));
      if (tog && k != 15) begin
        step();
        chk_idle("gap");
      end
    end
    chk("fe_in_ready", dut_if.in_ready, 0);
    chk("frame_done", dut_if.frame_done, 1);
    step();
    chk("fd_clear", dut_if.frame_done, 0);
    chk("fill_in_ready", dut_if.in_ready, 1);
    chk("fill_win_valid", dut_if.win_valid, 0);
  endtask

  initial begin
    rst              = 1'b1;
    dut_if.in_valid  = 1'b0;
    dut_if.win_ready = 1'b1;
    drive(0);

    do_reset();
    run_frame(1'b0, 1'b0);

    do_reset();
    run_frame(1'b1, 1'b0);

    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      send(k);
      chk_idle("partial");
    end
    do_reset();
    run_frame(1'b0, 1'b0);

    run_frame(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
